dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
// - Bus-side data memory that answers load/store requests from the core's data port (or a bus bridge) over a valid/ready request/response handshake.
// - Unlike the single-cycle dmem, it has a configurable access latency, one outstanding transaction and a response channel with an error flag.
// - Lets the core move to a stalling, multi-cycle memory model.
// PARAMETERS
// - MEM_SIZE_KB  default 1  storage size in KiB; byte array of MEM_SIZE_KB*1024 entries, little-endian.
// - LATENCY      default 2  cycles from the accept edge to rspValid; legal range 1..15.
// PORTS
// - clk         input   1   clock; every register updates on the rising edge.
// - reset       input   1   synchronous, active-high reset.
// - reqValid    input   1   request present.
// - reqReady    output  1   responder can accept a request this cycle.
// - reqWrite    input   1   1 = store, 0 = load.
// - reqFunct3   input   3   RV32 access size/sign encoding, same as the funct3 field.
// - reqAddr     input   32  byte address.
// - reqWdata    input   32  store data; valid bytes are taken from the LSBs.
// - rspValid    output  1   response present.
// - rspReady    input   1   consumer accepts the response.
// - rspRdata    output  32  load result after extension; 0 for stores and for errors.
// - rspErr      output  1   request was illegal.
// BEHAVIOUR
// - FSM states and transitions:
//   - IDLE -> WAIT on accept (reqValid && reqReady).
//   - WAIT counts down from LATENCY-1; -> RESP when the count reaches 0.
//   - If LATENCY==1, IDLE goes directly to RESP.
//   - RESP -> IDLE when rspValid && rspReady.
// - Handshake rules:
//   - reqReady = 1 only in IDLE, so at most one transaction is outstanding.
//   - Request fields are captured at the accept edge; later input changes are ignored.
//   - Once rspValid rises, rspRdata and rspErr stay stable until the response handshake completes.
// - Latency: rspValid is asserted exactly LATENCY cycles after the accept edge and holds until rspReady is 1.
// - Reset: state = IDLE, counter = 0, rspValid = 0, rspRdata = 0, rspErr = 0.
//   - reqReady is 0 during the reset cycle and 1 on the first cycle after reset.
//   - Memory contents are not reset.
// - Reset mid-operation: any in-flight transaction is dropped and no response is issued.
//   - A store that was already committed stays committed.
// - Loads:
//   - Encodings: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
//   - Data is read from the array on the WAIT->RESP (or IDLE->RESP) edge.
//   - LB/LH sign-extend; LBU/LHU zero-extend.
// - Stores:
//   - Encodings: 000 SB, 001 SH, 010 SW.
//   - The write commits on the accept edge, only to the addressed bytes; other bytes are unchanged.
// - Errors (rspErr = 1, no array write, rspRdata = 0):
//   - illegal funct3 (loads 011/110/111; stores 011 and above);
//   - reqAddr >= MEM_SIZE_KB*1024;
//   - an access whose last byte is beyond the end of memory.
//   - The response keeps its normal latency in every error case.
// - Address decode: only bits [$clog2(MEM_SIZE_KB*1024)-1:0] index the array, after the range check.
// - Simultaneous rspValid && rspReady in RESP: go to IDLE; the next request can be accepted on the following cycle (no back-to-back bypass).
// CONFIGURATION
// - Macro DMEM_RESPONDER_MISALIGN_TRAP_EN.
// - Defined: a halfword at an odd address, or a word whose addr[1:0] != 0, is an error with rspErr = 1 and no write.
// - Undefined: the low address bits are forced to zero (halfword addr[0], word addr[1:0]); the access completes on the aligned location with rspErr = 0.
// TESTING
// 1. SW addr 0x10 data 0xDEADBEEF, then LW 0x10
//    -> rspValid exactly 2 cycles after each accept; LW returns 0xDEADBEEF, rspErr = 0.
// 2. After test 1: SB 0x11 data 0x55, then LB 0x11 / LBU 0x13 / LH 0x12 / LHU 0x12
//    -> 0x00000055 / 0x000000DE / 0xFFFFDEAD / 0x0000DEAD.
// 3. LW at 0x400 (MEM_SIZE_KB = 1) and a load with funct3 = 011
//    -> rspErr = 1, rspRdata = 0, normal latency; a following LW 0x3FC is unaffected.
// 4. Hold rspReady = 0 for 5 cycles during a load
//    -> rspValid and rspRdata stable, reqReady = 0 throughout;
//    rspReady = 1 -> IDLE the next cycle, reqReady = 1.
// 5. LW 0x12 with the macro on -> rspErr = 1.
//    LW 0x12 with the macro off -> data of 0x10, rspErr = 0.
// 6. Assert reset 1 cycle after accepting a load, then issue a new LW
//    -> no response for the first load; only the new LW responds, with correct data.

Source files
------------

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - byte-addressed data memory behind a valid/ready request/response handshake
// Optional build macro DMEM_RESPONDER_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into errors.
module dmem_responder #(
  parameter int MEM_SIZE_KB = 1,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [2:0]  reqFunct3,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqWdata,
  output logic        rspValid,
  input  logic        rspReady,
  output logic [31:0] rspRdata,
  output logic        rspErr
);

  localparam int DEPTH = MEM_SIZE_KB * 1024;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t         state;
  logic [3:0]     cnt;
  logic [7:0]     mem [DEPTH];

  logic           cap_write;
  logic           cap_err;
  logic [2:0]     cap_funct3;
  logic [AW-1:0]  cap_idx;

  logic           accept;
  logic [1:0]     nbytes_m1;
  logic           bad_f3;
  logic           misalign;
  logic [31:0]    eff_addr;
  logic [32:0]    last_byte;
  logic           req_err;

  logic           use_req;
  logic [AW-1:0]  rd_idx;
  logic [2:0]     rd_f3;
  logic           rd_write;
  logic           rd_err;
  logic [31:0]    rd_word;
  logic [31:0]    rsp_data_next;

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] w);
    case (f3)
      3'b000:  extend = {{24{w[7]}}, w[7:0]};
      3'b001:  extend = {{16{w[15]}}, w[15:0]};
      3'b100:  extend = {24'b0, w[7:0]};
      3'b101:  extend = {16'b0, w[15:0]};
      default: extend = w;
    endcase
  endfunction

  assign reqReady = (state == IDLE) && !reset;
  assign accept   = reqValid && reqReady;

  // Request decode: access size, legality, alignment and range, from the live inputs.
  always_comb begin
    case (reqFunct3[1:0])
      2'b01:   nbytes_m1 = 2'd1;
      2'b10:   nbytes_m1 = 2'd3;
      default: nbytes_m1 = 2'd0;
    endcase
    bad_f3   = reqWrite ? (reqFunct3 > 3'd2) : ((reqFunct3[1:0] == 2'b11) || (reqFunct3 == 3'b110));
    eff_addr = reqAddr;
    misalign = 1'b0;
`ifdef DMEM_RESPONDER_MISALIGN_TRAP_EN
    case (reqFunct3[1:0])
      2'b01:   misalign = reqAddr[0];
      2'b10:   misalign = |reqAddr[1:0];
      default: misalign = 1'b0;
    endcase
`else
    case (reqFunct3[1:0])
      2'b01:   eff_addr[0]   = 1'b0;
      2'b10:   eff_addr[1:0] = 2'b00;
      default: eff_addr      = reqAddr;
    endcase
`endif
    last_byte = {1'b0, eff_addr} + {31'b0, nbytes_m1};
    req_err   = bad_f3 || misalign || (reqAddr >= 32'(DEPTH)) || (last_byte >= 33'(DEPTH));
  end

  // With LATENCY==1 the response is built straight from the request being accepted.
  always_comb begin
    use_req       = (state == IDLE);
    rd_idx        = use_req ? eff_addr[AW-1:0] : cap_idx;
    rd_f3         = use_req ? reqFunct3 : cap_funct3;
    rd_write      = use_req ? reqWrite : cap_write;
    rd_err        = use_req ? req_err : cap_err;
    rd_word       = {mem[rd_idx + AW'(3)], mem[rd_idx + AW'(2)], mem[rd_idx + AW'(1)], mem[rd_idx]};
    rsp_data_next = (rd_write || rd_err) ? 32'b0 : extend(rd_f3, rd_word);
  end

  // Stores commit on the accept edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && reqWrite && !req_err) begin
      mem[eff_addr[AW-1:0]] <= reqWdata[7:0];
      if (reqFunct3[1:0] != 2'b00) begin
        mem[eff_addr[AW-1:0] + AW'(1)] <= reqWdata[15:8];
      end
      if (reqFunct3[1:0] == 2'b10) begin
        mem[eff_addr[AW-1:0] + AW'(2)] <= reqWdata[23:16];
        mem[eff_addr[AW-1:0] + AW'(3)] <= reqWdata[31:24];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      rspValid <= 1'b0;
      rspRdata <= 32'b0;
      rspErr   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cap_write  <= reqWrite;
            cap_err    <= req_err;
            cap_funct3 <= reqFunct3;
            cap_idx    <= eff_addr[AW-1:0];
            if (LATENCY == 1) begin
              state    <= RESP;
              rspValid <= 1'b1;
              rspErr   <= req_err;
              rspRdata <= rsp_data_next;
            end else begin
              state <= WAIT;
              cnt   <= 4'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (cnt <= 4'd1) begin
            state    <= RESP;
            cnt      <= 4'd0;
            rspValid <= 1'b1;
            rspErr   <= cap_err;
            rspRdata <= rsp_data_next;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rspReady) begin
            state    <= IDLE;
            rspValid <= 1'b0;
            rspRdata <= 32'b0;
            rspErr   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
